// File: rtl/versacore_fp_unpack_if.sv
// Operand/result bus of the FP unpack stage: elastic operand input and
// elastic unpacked-result output grouped into one interface.
interface versacore_fp_unpack_if #(
    parameter int WIDTH     = 32,
    parameter int EXP_OUT_W = 10,
    parameter int MAN_OUT_W = 24
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     in_data_i;
    logic [2:0]           in_fmt_i;

    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 out_sign_o;
    logic [EXP_OUT_W-1:0] out_exp_o;
    logic [MAN_OUT_W-1:0] out_man_o;
    logic [7:0]           out_info_o;
    logic [2:0]           out_fmt_o;
    logic                 out_fmt_err_o;

    modport slave (
        input  in_valid_i, in_data_i, in_fmt_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sign_o, out_exp_o, out_man_o,
               out_info_o, out_fmt_o, out_fmt_err_o
    );

    modport master (
        output in_valid_i, in_data_i, in_fmt_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sign_o, out_exp_o, out_man_o,
               out_info_o, out_fmt_o, out_fmt_err_o
    );
endinterface

// File: rtl/versacore_fp_unpack.sv
// Two-stage elastic unpack of a NaN-boxed FP32/FP16/FP8/FP16ALT operand into
// sign, unbiased exponent, normalized mantissa and class flags.
module versacore_fp_unpack #(
    parameter int WIDTH     = 32,
    parameter int EXP_OUT_W = 10,
    parameter int MAN_OUT_W = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    versacore_fp_unpack_if.slave  bus
);

    typedef enum logic [2:0] {
        FMT_FP32    = 3'd0,
        FMT_FP64    = 3'd1,
        FMT_FP16    = 3'd2,
        FMT_FP8     = 3'd3,
        FMT_FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic normal;
        logic subnormal;
        logic zero;
        logic inf;
        logic nan;
        logic signalling;
        logic quiet;
        logic boxed;
    } fp_info_t;

    function automatic logic [4:0] lzc23(input logic [22:0] v);
        lzc23 = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (v[i]) lzc23 = 5'(22 - i);
        end
    endfunction

    // Handshake: a transfer happens on an edge where valid && ready. Each
    // stage register loads whenever its own ready is high (empty, or the
    // downstream slot drains this edge); flush clears both valids.
    logic s1_valid, s2_valid;
    logic s1_ready, s2_ready;

    assign s2_ready       = !s2_valid || bus.out_ready_i;
    assign s1_ready       = !s1_valid || s2_ready;
    assign bus.in_ready_o = s1_ready;

    // ---------------- stage 1: field slicing and classification ----------
    logic        d_sign, d_emax, d_boxed, d_fmt_ok;
    logic [7:0]  d_e;
    logic [22:0] d_m;

    always_comb begin
        d_sign   = 1'b0;
        d_e      = 8'd0;
        d_m      = 23'd0;
        d_emax   = 1'b0;
        d_boxed  = 1'b1;
        d_fmt_ok = 1'b1;
        // Mantissa fields are stored MSB-aligned in 23 bits so stage 2 is format-agnostic.
        case (fp_format_e'(bus.in_fmt_i))
            FMT_FP32: begin
                d_sign = bus.in_data_i[31];
                d_e    = bus.in_data_i[30:23];
                d_m    = bus.in_data_i[22:0];
                d_emax = &bus.in_data_i[30:23];
            end
            FMT_FP16: begin
                d_sign  = bus.in_data_i[15];
                d_e     = {3'd0, bus.in_data_i[14:10]};
                d_m     = {bus.in_data_i[9:0], 13'd0};
                d_emax  = &bus.in_data_i[14:10];
                d_boxed = &bus.in_data_i[WIDTH-1:16];
            end
            FMT_FP8: begin
                d_sign  = bus.in_data_i[7];
                d_e     = {3'd0, bus.in_data_i[6:2]};
                d_m     = {bus.in_data_i[1:0], 21'd0};
                d_emax  = &bus.in_data_i[6:2];
                d_boxed = &bus.in_data_i[WIDTH-1:8];
            end
            FMT_FP16ALT: begin
                d_sign  = bus.in_data_i[15];
                d_e     = bus.in_data_i[14:7];
                d_m     = {bus.in_data_i[6:0], 16'd0};
                d_emax  = &bus.in_data_i[14:7];
                d_boxed = &bus.in_data_i[WIDTH-1:16];
            end
            default: d_fmt_ok = 1'b0;
        endcase
    end

    logic        s1_sign, s1_emax, s1_ezero, s1_mzero, s1_boxed, s1_fmt_ok;
    logic [7:0]  s1_e;
    logic [22:0] s1_m;
    logic [4:0]  s1_lz;
    logic [2:0]  s1_fmt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_e      <= 8'd0;
            s1_m      <= 23'd0;
            s1_lz     <= 5'd0;
            s1_emax   <= 1'b0;
            s1_ezero  <= 1'b0;
            s1_mzero  <= 1'b0;
            s1_boxed  <= 1'b0;
            s1_fmt_ok <= 1'b0;
            s1_fmt    <= 3'd0;
        end else begin
            if (flush_i)       s1_valid <= 1'b0;
            else if (s1_ready) s1_valid <= bus.in_valid_i;
            if (s1_ready && bus.in_valid_i) begin
                s1_sign   <= d_sign;
                s1_e      <= d_e;
                s1_m      <= d_m;
                s1_lz     <= lzc23(d_m);
                s1_emax   <= d_emax;
                s1_ezero  <= (d_e == 8'd0);
                s1_mzero  <= (d_m == 23'd0);
                s1_boxed  <= d_boxed;
                s1_fmt_ok <= d_fmt_ok;
                s1_fmt    <= bus.in_fmt_i;
            end
        end
    end

    // ---------------- stage 2: normalization ------------------------------
    logic [EXP_OUT_W-1:0] bias;
    logic                 n_sign, n_err;
    logic [EXP_OUT_W-1:0] n_exp;
    logic [23:0]          n_man;
    fp_info_t             n_info;

    assign bias = (s1_fmt == FMT_FP16 || s1_fmt == FMT_FP8) ? EXP_OUT_W'(15)
                                                            : EXP_OUT_W'(127);

    always_comb begin
        n_sign = s1_sign;
        n_exp  = '0;
        n_man  = 24'd0;
        n_info = '0;
        n_err  = 1'b0;
        if (!s1_fmt_ok) begin
            n_sign       = 1'b0;
            n_exp        = EXP_OUT_W'(128);
            n_man        = 24'hC0_0000;
            n_info.nan   = 1'b1;
            n_info.quiet = 1'b1;
            n_info.boxed = 1'b1;
            n_err        = 1'b1;
        end else if (!s1_boxed) begin
            n_sign       = 1'b0;
            n_exp        = bias + EXP_OUT_W'(1);
            n_man        = 24'hC0_0000;
            n_info.nan   = 1'b1;
            n_info.quiet = 1'b1;
        end else if (s1_emax) begin
            n_exp        = bias + EXP_OUT_W'(1);
            n_info.boxed = 1'b1;
            if (s1_mzero) begin
                n_info.inf = 1'b1;
            end else begin
                n_man             = {1'b1, s1_m};
                n_info.nan        = 1'b1;
                n_info.quiet      = s1_m[22];
                n_info.signalling = !s1_m[22];
            end
        end else if (s1_ezero) begin
            n_info.boxed = 1'b1;
            if (s1_mzero) begin
                n_info.zero = 1'b1;
            end else begin
                // 1 - bias - (lz+1) collapses to -bias - lz
                n_man            = {1'b0, s1_m} << (s1_lz + 5'd1);
                n_exp            = EXP_OUT_W'(0) - bias - EXP_OUT_W'(s1_lz);
                n_info.subnormal = 1'b1;
            end
        end else begin
            n_exp         = EXP_OUT_W'(s1_e) - bias;
            n_man         = {1'b1, s1_m};
            n_info.normal = 1'b1;
            n_info.boxed  = 1'b1;
        end
    end

    logic                 s2_sign, s2_err;
    logic [EXP_OUT_W-1:0] s2_exp;
    logic [MAN_OUT_W-1:0] s2_man;
    logic [7:0]           s2_info;
    logic [2:0]           s2_fmt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_man   <= '0;
            s2_info  <= 8'd0;
            s2_fmt   <= 3'd0;
            s2_err   <= 1'b0;
        end else begin
            if (flush_i)       s2_valid <= 1'b0;
            else if (s2_ready) s2_valid <= s1_valid;
            if (s2_ready && s1_valid) begin
                s2_sign <= n_sign;
                s2_exp  <= n_exp;
                s2_man  <= MAN_OUT_W'(n_man) << (MAN_OUT_W - 24);
                s2_info <= n_info;
                s2_fmt  <= s1_fmt;
                s2_err  <= n_err;
            end
        end
    end

    assign bus.out_valid_o   = s2_valid;
    assign bus.out_sign_o    = s2_sign;
    assign bus.out_exp_o     = s2_exp;
    assign bus.out_man_o     = s2_man;
    assign bus.out_info_o    = s2_info;
    assign bus.out_fmt_o     = s2_fmt;
    assign bus.out_fmt_err_o = s2_err;

endmodule
